// File: rtl/mod_mul_pkg.sv
// rtl/mod_mul_pkg.sv - shared state encoding, legality helper and reference step for mod_mul_iter
package mod_mul_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Bit n set means n multiplier bits per cycle is a supported configuration (1, 2, 4).
  localparam int BPC_LEGAL_MASK = 22;

  localparam int REF_WIDTH = 256;
  typedef logic [REF_WIDTH-1:0] ref_word_t;

  function automatic logic bpc_is_legal(input int bpc);
    return (bpc > 0) && (bpc < 31) && (((BPC_LEGAL_MASK >> bpc) & 1) != 0);
  endfunction

  // One interleaved step: double and reduce, then conditionally add a and reduce.
  function automatic ref_word_t mod_step(input ref_word_t acc, input ref_word_t a,
                                         input ref_word_t p, input logic b_bit);
    logic [REF_WIDTH:0] t;
    t = {acc, 1'b0};
    if (t >= {1'b0, p}) t = t - {1'b0, p};
    if (b_bit) begin
      t = t + {1'b0, a};
      if (t >= {1'b0, p}) t = t - {1'b0, p};
    end
    return t[REF_WIDTH-1:0];
  endfunction

  // Full a*b mod p built from mod_step, scanning b MSB first.
  function automatic ref_word_t mod_mul_ref(input ref_word_t a, input ref_word_t b,
                                            input ref_word_t p);
    ref_word_t acc;
    acc = '0;
    for (int i = REF_WIDTH - 1; i >= 0; i--) acc = mod_step(acc, a, p, b[i]);
    return acc;
  endfunction

endpackage

// File: rtl/mod_mul_iter_if.sv
// rtl/mod_mul_iter_if.sv - request/result handshake bundle for mod_mul_iter
interface mod_mul_iter_if #(
  parameter int WIDTH     = 256,
  parameter int TAG_WIDTH = 8
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [WIDTH-1:0]     in_p;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_r;
  logic                 out_err;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 busy;

  modport master (
    output in_valid, in_a, in_b, in_p, in_tag, out_ready,
    input  in_ready, out_valid, out_r, out_err, out_tag, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_p, in_tag, out_ready,
    output in_ready, out_valid, out_r, out_err, out_tag, busy
  );
endinterface

// File: rtl/mod_mul_step.sv
// rtl/mod_mul_step.sv - one combinational double/add/reduce step of the interleaved multiplier
module mod_mul_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_p,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_acc
);
  logic [WIDTH:0]   w_p_ext;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH-1:0] w_dbl_red;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sum_red;

  // acc < p and a < p, so each reduced value fits in WIDTH bits and the
  // subtraction can be done at WIDTH bits once the WIDTH+1 compare says so.
  assign w_p_ext   = {1'b0, i_p};
  assign w_dbl     = {i_acc, 1'b0};
  assign w_dbl_red = (w_dbl >= w_p_ext) ? (w_dbl[WIDTH-1:0] - i_p) : w_dbl[WIDTH-1:0];
  assign w_sum     = {1'b0, w_dbl_red} + {1'b0, i_a};
  assign w_sum_red = (w_sum >= w_p_ext) ? (w_sum[WIDTH-1:0] - i_p) : w_sum[WIDTH-1:0];
  assign o_acc     = i_bit ? w_sum_red : w_dbl_red;
endmodule

// File: rtl/mod_mul_iter.sv
// rtl/mod_mul_iter.sv - iterative interleaved modular multiplier r = a*b mod p with tag passthrough
module mod_mul_iter #(
  parameter int WIDTH          = 256,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_WIDTH      = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  mod_mul_iter_if.slave bus
);
  import mod_mul_pkg::*;

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);

  if (!bpc_is_legal(BITS_PER_CYCLE) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("mod_mul_iter: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
  end

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_p;
  logic [WIDTH-1:0]     r_acc;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_out_r;
  logic                 r_out_err;
  logic [TAG_WIDTH-1:0] r_out_tag;

  logic                 w_accept;
  logic                 w_err;
  logic                 w_last;
  logic [WIDTH-1:0]     w_chain [0:BITS_PER_CYCLE];

  // A finished result being taken frees the block in the same cycle.
  assign bus.in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_err         = (bus.in_a >= bus.in_p) || (bus.in_b >= bus.in_p) ||
                         (bus.in_p < WIDTH'(2));
  assign w_last        = (r_cnt == CNT_W'(1));

  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_r     = r_out_r;
  assign bus.out_err   = r_out_err;
  assign bus.out_tag   = r_out_tag;
  assign bus.busy      = (r_state != ST_IDLE);

  // Chain of single-bit steps consuming the top BITS_PER_CYCLE bits of b, MSB first.
  assign w_chain[0] = r_acc;
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    mod_mul_step #(.WIDTH(WIDTH)) u_step (
      .i_acc (w_chain[k]),
      .i_a   (r_a),
      .i_p   (r_p),
      .i_bit (r_b[WIDTH-1-k]),
      .o_acc (w_chain[k+1])
    );
  end

  // Control and datapath: latch on accept, iterate in RUN, hold result in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_p       <= '0;
      r_acc     <= '0;
      r_tag     <= '0;
      r_cnt     <= '0;
      r_out_r   <= '0;
      r_out_err <= 1'b0;
      r_out_tag <= '0;
    end else if (w_accept) begin
      r_a   <= bus.in_a;
      r_b   <= bus.in_b;
      r_p   <= bus.in_p;
      r_tag <= bus.in_tag;
      r_acc <= '0;
      r_cnt <= CNT_W'(STEPS);
      if (w_err) begin
        r_state   <= ST_DONE;
        r_out_r   <= '0;
        r_out_err <= 1'b1;
        r_out_tag <= bus.in_tag;
      end else begin
        r_state <= ST_RUN;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          r_acc <= w_chain[BITS_PER_CYCLE];
          r_b   <= r_b << BITS_PER_CYCLE;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_state   <= ST_DONE;
            r_out_r   <= w_chain[BITS_PER_CYCLE];
            r_out_err <= 1'b0;
            r_out_tag <= r_tag;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mod_mul_iter.md
Name: mod_mul_iter

Overview:
- Parametrised, iterative, interleaved (shift-add-reduce) modular multiplier: r = (a*b) mod p.
- Generalises the fixed-width, start/done multiplier to configurable WIDTH, BITS_PER_CYCLE, runtime modulus, tag passthrough and valid/ready on both sides.
- Sits between the MSM point-arithmetic controller and the field-op scheduler; one operation in flight.

Parameters:
- WIDTH, 256, operand/modulus/result width in bits.
- BITS_PER_CYCLE, 1, multiplier bits consumed per cycle; legal values 1, 2, 4; WIDTH % BITS_PER_CYCLE == 0 (elaboration error otherwise).
- TAG_WIDTH, 8, opaque tag carried from input to output.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier (scanned MSB first).
- in_p  in  WIDTH  modulus, odd or even, must be >= 2.
- in_tag  in  TAG_WIDTH  request tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_r  out  WIDTH  result.
- out_err  out  1  operand check failed.
- out_tag  out  TAG_WIDTH  tag of this result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, out_valid=0, out_r=0, out_err=0, out_tag=0, busy=0; all internal registers cleared.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
- On accept:
  - Latch a, b, p, tag.
  - acc=0; cnt=WIDTH/BITS_PER_CYCLE.
  - err = (a>=p) | (b>=p) | (p<2).
  - Go to RUN if !err, else go directly to DONE with out_r=0, out_err=1 (latency 1 cycle).
- RUN, each cycle, unrolled BITS_PER_CYCLE times combinationally, MSB of b first:
  - acc = 2*acc; if acc>=p then acc-=p.
  - If bit set: acc += a; if acc>=p then acc-=p.
  - Intermediate width is WIDTH+1 (no overflow since acc, a < p).
  - b shifts left by BITS_PER_CYCLE; cnt decrements.
- When cnt reaches 1 in RUN, next edge: state=DONE, out_r=final acc, out_err=0, out_tag=latched tag.
- Latency: out_valid rises exactly WIDTH/BITS_PER_CYCLE cycles after the accept edge (no error); 1 cycle (error).
- DONE: out_valid=1; out_r/out_err/out_tag held stable until out_valid & out_ready.
- On result handshake:
  - If a new accept occurs in the same cycle, load it (back-to-back; no IDLE bubble).
  - Otherwise go to IDLE, out_valid=0.
- in_* changes while not accepted are ignored; operands are used only from the latch.
- reset_n low mid-RUN or mid-DONE: operation discarded, outputs to reset values immediately, no result emitted.
- Edge cases that must match the reference model: b=0 or a=0 -> 0; a=b=p-1 -> 1; p=2 -> a*b&1.

Decomposition:
- Package mod_mul_pkg: state enum typedef (IDLE/RUN/DONE), localparam for legal BITS_PER_CYCLE set, function for a single step (double-reduce, conditional add-reduce) reused by verification model.
- One sub-module natural: mod_mul_step (combinational, one BITS_PER_CYCLE=1 step, WIDTH-parametrised); mod_mul_iter instantiates BITS_PER_CYCLE copies in a chain.

Test Plan:
- WIDTH=8, BPC=1, p=251, a=200, b=100, tag=0x5A, out_ready=1 -> out_valid exactly 8 cycles after accept, out_r=171, out_err=0, out_tag=0x5A.
- WIDTH=8, BPC=2, p=251, a=250, b=250 -> out_r=1 after 4 cycles; a=0, b=123 -> out_r=0.
- p=251, a=251, b=5 -> out_valid 1 cycle after accept, out_err=1, out_r=0; p=1 also -> out_err=1.
- out_ready=0 for 5 cycles in DONE -> out_r/out_tag stable, in_ready=0; then out_ready=1 with in_valid=1 -> result consumed and next request accepted the same cycle, next result 8 cycles later.
- reset_n pulsed low at cycle 3 of RUN -> out_valid, busy, out_r drop to 0 asynchronously; no result emitted; next request (p=251, a=2, b=3) -> 6.
- Random: WIDTH=256, BPC in {1,2,4}, 2000 random a, b < p (BN254 base-field prime) with random out_ready stalls -> all results match the package reference function, in order, tags preserved.
